// File: rtl/core_mem_stage.sv
// Memory-access pipeline stage: registers execute results, runs loads/stores over a
// request/grant/response handshake, aligns store lanes and extends load data for writeback.
module core_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ex_valid,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic [4:0]      i_rd,
    input  logic            i_reg_write,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_store_data,
    input  logic [XLEN-1:0] i_csr_data,
    output logic            o_stall,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_be,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_wb_valid,
    output logic [4:0]      o_wb_rd,
    output logic            o_wb_reg_write,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_misaligned
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state, state_next;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic            reg_write_q;
    logic [1:0]      off_q;

    logic            is_load, is_store, is_mem, misaligned;
    logic [1:0]      off;
    logic [XLEN-1:0] store_wdata, load_data;
    logic [3:0]      store_be;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;

    always_comb begin
        is_load  = (i_opcode == OP_LOAD);
        is_store = (i_opcode == OP_STORE);
        is_mem   = is_load | is_store;
        off      = i_alu_result[1:0];
        case (i_funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    end

    // Store data is replicated across every lane so the memory only needs the byte enables.
    always_comb begin
        case (i_funct3[1:0])
            2'b00: begin
                store_wdata = {4{i_store_data[7:0]}};
                store_be    = 4'b0001 << off;
            end
            2'b01: begin
                store_wdata = {2{i_store_data[15:0]}};
                store_be    = 4'b0011 << off;
            end
            default: begin
                store_wdata = i_store_data;
                store_be    = 4'b1111;
            end
        endcase
    end

    always_comb begin
        case (off_q)
            2'd0:    load_byte = i_dmem_rdata[7:0];
            2'd1:    load_byte = i_dmem_rdata[15:8];
            2'd2:    load_byte = i_dmem_rdata[23:16];
            default: load_byte = i_dmem_rdata[31:24];
        endcase
        load_half = off_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'd0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = i_dmem_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_ex_valid && is_mem && !misaligned) state_next = REQ;
            REQ:     if (i_dmem_gnt) state_next = o_dmem_we ? IDLE : WAIT;
            WAIT:    if (i_dmem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign o_stall    = (state != IDLE);
    assign o_dmem_req = (state == REQ);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    // Request fields are latched once at accept so they stay stable until grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            funct3_q       <= '0;
            rd_q           <= '0;
            reg_write_q    <= 1'b0;
            off_q          <= '0;
            o_dmem_we      <= 1'b0;
            o_dmem_addr    <= '0;
            o_dmem_wdata   <= '0;
            o_dmem_be      <= '0;
            o_wb_valid     <= 1'b0;
            o_wb_rd        <= '0;
            o_wb_reg_write <= 1'b0;
            o_wb_data      <= '0;
            o_misaligned   <= 1'b0;
        end else begin
            o_wb_valid     <= 1'b0;
            o_wb_reg_write <= 1'b0;
            o_misaligned   <= 1'b0;
            case (state)
                IDLE: if (i_ex_valid) begin
                    funct3_q    <= i_funct3;
                    rd_q        <= i_rd;
                    reg_write_q <= i_reg_write;
                    off_q       <= off;
                    if (!is_mem) begin
                        o_wb_valid     <= 1'b1;
                        o_wb_rd        <= i_rd;
                        o_wb_reg_write <= i_reg_write;
                        o_wb_data      <= (i_opcode == OP_SYSTEM) ? i_csr_data : i_alu_result;
                    end else if (misaligned) begin
                        o_wb_valid   <= 1'b1;
                        o_wb_rd      <= i_rd;
                        o_wb_data    <= i_alu_result;
                        o_misaligned <= 1'b1;
                    end else begin
                        o_dmem_we    <= is_store;
                        o_dmem_addr  <= {i_alu_result[XLEN-1:2], 2'b00};
                        o_dmem_wdata <= store_wdata;
                        o_dmem_be    <= store_be;
                    end
                end
                REQ: if (i_dmem_gnt && o_dmem_we) begin
                    o_wb_valid <= 1'b1;
                    o_wb_rd    <= rd_q;
                end
                WAIT: if (i_dmem_rvalid) begin
                    o_wb_valid     <= 1'b1;
                    o_wb_rd        <= rd_q;
                    o_wb_reg_write <= reg_write_q;
                    o_wb_data      <= load_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_stage.sv
// Bench for core_mem_stage: hand-written vector table, randomized instructions checked
// against an arithmetic reference model, and reset-abandon / back-to-back sequences.
module tb_core_mem_stage;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;

    logic        clk = 1'b0, rst = 1'b1;
    logic        ex_valid = 1'b0, reg_write = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd = '0;
    logic [31:0] alu_result = '0, store_data = '0, csr_data = '0, dmem_rdata = '0;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic        stall, dmem_req, dmem_we, wb_valid, wb_reg_write, misaligned;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_rd;

    int tests = 0;
    int failed = 0;

    core_mem_stage #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_ex_valid(ex_valid), .i_opcode(opcode),
        .i_funct3(funct3), .i_rd(rd), .i_reg_write(reg_write), .i_alu_result(alu_result),
        .i_store_data(store_data), .i_csr_data(csr_data), .o_stall(stall),
        .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
        .o_dmem_wdata(dmem_wdata), .o_dmem_be(dmem_be), .i_dmem_gnt(dmem_gnt),
        .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata), .o_wb_valid(wb_valid),
        .o_wb_rd(wb_rd), .o_wb_reg_write(wb_reg_write), .o_wb_data(wb_data),
        .o_misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] alu, sdata, csr, rdata;
        int          g, r;
        logic [31:0] e_data, e_addr, e_wdata;
        logic        e_mis, e_rw, chk_data;
        logic [3:0]  e_be;
        int          e_lat;
    } vec_t;

    function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic [4:0] d, logic w,
                                logic [31:0] a, logic [31:0] s, logic [31:0] c, logic [31:0] m,
                                int g, int r, logic [31:0] ed, logic emis, logic erw,
                                logic [31:0] ea, logic [31:0] ewd, logic [3:0] ebe, int elat,
                                logic chk);
        vec_t v;
        v.opcode = op; v.funct3 = f3; v.rd = d; v.rw = w; v.alu = a; v.sdata = s;
        v.csr = c; v.rdata = m; v.g = g; v.r = r; v.e_data = ed; v.e_mis = emis;
        v.e_rw = erw; v.e_addr = ea; v.e_wdata = ewd; v.e_be = ebe; v.e_lat = elat;
        v.chk_data = chk;
        return v;
    endfunction

    // Reference model: computes the expected effect of one instruction from byte arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t   e = v;
        int     size, off;
        longint span, val, mult;
        bit     ld = (v.opcode == OP_LOAD);
        bit     st = (v.opcode == OP_STORE);
        off  = int'(v.alu % 32'd4);
        size = 1 << v.funct3[1:0];
        span = longint'(1) << (8 * size);
        e.e_mis = 1'b0; e.chk_data = 1'b1; e.e_addr = v.alu - 32'(off);
        e.e_wdata = '0; e.e_be = '0;
        if (!ld && !st) begin
            e.e_data = (v.opcode == OP_SYSTEM) ? v.csr : v.alu;
            e.e_rw = v.rw; e.e_lat = 1;
        end else if (off % size != 0) begin
            e.e_mis = 1'b1; e.e_rw = 1'b0; e.e_lat = 1; e.chk_data = 1'b0;
        end else if (st) begin
            val  = longint'(v.sdata) % span;
            mult = (size == 1) ? 64'h01010101 : (size == 2) ? 64'h00010001 : 64'h1;
            e.e_wdata = 32'(val * mult);
            e.e_be = 4'(((1 << size) - 1) << off);
            e.e_rw = 1'b0; e.e_lat = 1 + v.g; e.chk_data = 1'b0;
        end else begin
            val = (longint'(v.rdata) >> (8 * off)) % span;
            if (v.funct3 < 3'd4 && size < 4 && val >= span / 2) val = val - span;
            e.e_data = 32'(val);
            e.e_rw = v.rw; e.e_lat = 1 + v.g + v.r;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one instruction starting at the current negedge, plays the memory side, and
    // checks the writeback beat, request fields, latency and stall time.
    task automatic applyStimulus(input vec_t v, input string tag);
        int cyc = 0, req_cnt = 0, wait_cnt = 0, stall_cnt = 0, unstable = 0;
        bit done = 0;
        logic [31:0] r_addr = '0, r_wdata = '0, first_addr = '0;
        logic [3:0]  r_be = '0;
        logic        r_we = 1'b0;
        logic [31:0] o_data = '0;
        logic [4:0]  o_rd = '0;
        logic        o_rw = 1'b0, o_mis = 1'b0;
        bit          is_mem = (v.opcode == OP_LOAD) || (v.opcode == OP_STORE);

        checkOutput({tag, ".idle_stall"}, 32'(stall), 32'd0);
        ex_valid = 1'b1; opcode = v.opcode; funct3 = v.funct3; rd = v.rd; reg_write = v.rw;
        alu_result = v.alu; store_data = v.sdata; csr_data = v.csr;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (wb_valid) begin
                done = 1;
                o_data = wb_data; o_rd = wb_rd; o_rw = wb_reg_write; o_mis = misaligned;
                ex_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'($urandom % 2);
            end else begin
                if (stall) stall_cnt++;
                if (dmem_req) begin
                    req_cnt++;
                    if (req_cnt == 1) first_addr = dmem_addr;
                    else if (dmem_addr !== first_addr) unstable++;
                    r_addr = dmem_addr; r_wdata = dmem_wdata; r_be = dmem_be; r_we = dmem_we;
                    dmem_gnt = (req_cnt == v.g);
                    dmem_rvalid = dmem_gnt ? 1'b0 : 1'($urandom % 2);
                    dmem_rdata = $urandom;
                end else if (stall) begin
                    wait_cnt++;
                    dmem_gnt = 1'b0;
                    dmem_rvalid = (wait_cnt == v.r);
                    dmem_rdata = dmem_rvalid ? v.rdata : $urandom;
                end else begin
                    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
                end
                // A different instruction waits upstream while stalled; it must not be taken.
                ex_valid = stall; opcode = OP_ALU; alu_result = $urandom; rd = 5'($urandom);
            end
        end
        if (!done) checkOutput({tag, ".timeout"}, 32'd1, 32'd0);
        checkOutput({tag, ".latency"}, 32'(cyc), 32'(v.e_lat));
        checkOutput({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(v.e_lat - 1));
        checkOutput({tag, ".wb_rd"}, 32'(o_rd), 32'(v.rd));
        checkOutput({tag, ".wb_reg_write"}, 32'(o_rw), 32'(v.e_rw));
        checkOutput({tag, ".misaligned"}, 32'(o_mis), 32'(v.e_mis));
        if (v.chk_data) checkOutput({tag, ".wb_data"}, o_data, v.e_data);
        checkOutput({tag, ".req_cycles"}, 32'(req_cnt),
                    (is_mem && !v.e_mis) ? 32'(v.g) : 32'd0);
        if (req_cnt > 0) begin
            checkOutput({tag, ".addr"}, r_addr, v.e_addr);
            checkOutput({tag, ".addr_stable"}, 32'(unstable), 32'd0);
            checkOutput({tag, ".we"}, 32'(r_we), 32'(v.opcode == OP_STORE));
            if (v.opcode == OP_STORE) begin
                checkOutput({tag, ".wdata"}, r_wdata, v.e_wdata);
                checkOutput({tag, ".be"}, 32'(r_be), 32'(v.e_be));
            end
        end
        @(negedge clk);
        checkOutput({tag, ".wb_pulse"}, 32'(wb_valid), 32'd0);
    endtask

    vec_t vecs[12];
    vec_t rv;
    logic [2:0] ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [6:0] alu_ops[3] = '{OP_ALU, 7'b0010011, OP_SYSTEM};

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //           op        f3  rd  rw  alu           sdata         csr           rdata         g  r  e_data        mis rw  e_addr        e_wdata       be       lat chk
        vecs[0]  = mk(OP_ALU,   0, 5,  1, 32'h42,       0,            0,            0,            1, 1, 32'h42,       0,  1,  0,            0,            4'b0000, 1,  1);
        vecs[1]  = mk(OP_STORE, 0, 3,  1, 32'h1003,     32'hAB,       0,            0,            2, 1, 0,            0,  0,  32'h1000,     32'hABABABAB, 4'b1000, 3,  0);
        vecs[2]  = mk(OP_LOAD,  1, 7,  1, 32'h2002,     0,            0,            32'h80017FFF, 1, 1, 32'hFFFF8001, 0,  1,  32'h2000,     0,            4'b0000, 3,  1);
        vecs[3]  = mk(OP_LOAD,  5, 8,  1, 32'h2002,     0,            0,            32'h80017FFF, 1, 2, 32'h00008001, 0,  1,  32'h2000,     0,            4'b0000, 4,  1);
        vecs[4]  = mk(OP_LOAD,  2, 9,  1, 32'h3001,     0,            0,            0,            1, 1, 0,            1,  0,  0,            0,            4'b0000, 1,  0);
        vecs[5]  = mk(OP_LOAD,  0, 10, 1, 32'h4000,     0,            0,            32'h00000080, 1, 3, 32'hFFFFFF80, 0,  1,  32'h4000,     0,            4'b0000, 5,  1);
        vecs[6]  = mk(OP_SYSTEM,0, 11, 1, 32'h123,      0,            32'hDEADBEEF, 0,            1, 1, 32'hDEADBEEF, 0,  1,  0,            0,            4'b0000, 1,  1);
        vecs[7]  = mk(OP_STORE, 2, 12, 1, 32'h5004,     32'h12345678, 0,            0,            1, 1, 0,            0,  0,  32'h5004,     32'h12345678, 4'b1111, 2,  0);
        vecs[8]  = mk(OP_STORE, 1, 13, 1, 32'h600A,     32'hCAFEBEEF, 0,            0,            3, 1, 0,            0,  0,  32'h6008,     32'hBEEFBEEF, 4'b1100, 4,  0);
        vecs[9]  = mk(OP_LOAD,  4, 14, 1, 32'h7003,     0,            0,            32'hF1223344, 2, 1, 32'h000000F1, 0,  1,  32'h7000,     0,            4'b0000, 4,  1);
        vecs[10] = mk(OP_LOAD,  1, 15, 1, 32'h7001,     0,            0,            0,            1, 1, 0,            1,  0,  0,            0,            4'b0000, 1,  0);
        vecs[11] = mk(OP_LOAD,  2, 0,  1, 32'h8008,     0,            0,            32'hA5A5_0F0F,1, 1, 32'hA5A50F0F, 0,  1,  32'h8008,     0,            4'b0000, 3,  1);

        repeat (2) @(negedge clk);
        checkOutput("reset.stall", 32'(stall), 32'd0);
        checkOutput("reset.dmem_req", 32'(dmem_req), 32'd0);
        checkOutput("reset.dmem_we_be", {27'd0, dmem_we, dmem_be}, 32'd0);
        checkOutput("reset.wb_flags", {29'd0, wb_valid, wb_reg_write, misaligned}, 32'd0);
        checkOutput("reset.dmem_addr", dmem_addr, 32'd0);
        checkOutput("reset.dmem_wdata", dmem_wdata, 32'd0);
        checkOutput("reset.wb_data", wb_data, 32'd0);
        checkOutput("reset.wb_rd", 32'(wb_rd), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back non-memory instructions complete one per cycle.
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                checkOutput($sformatf("b2b%0d.valid", i), 32'(wb_valid), 32'd1);
                checkOutput($sformatf("b2b%0d.data", i), wb_data, 32'(i * 17));
                checkOutput($sformatf("b2b%0d.stall", i), 32'(stall), 32'd0);
            end
            ex_valid = (i < 3); opcode = OP_ALU; alu_result = 32'((i + 1) * 17);
            rd = 5'(i + 1); reg_write = 1'b1;
            @(negedge clk);
        end

        // Reset while waiting for load data abandons the access.
        ex_valid = 1'b1; opcode = OP_LOAD; funct3 = 3'd2; alu_result = 32'h100; rd = 5'd4;
        @(negedge clk);
        ex_valid = 1'b0;
        checkOutput("rstwait.req", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        checkOutput("rstwait.in_wait", {30'd0, stall, dmem_req}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234;
        checkOutput("rstwait.idle", {30'd0, stall, dmem_req}, 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        checkOutput("rstwait.no_wb", 32'(wb_valid), 32'd0);
        @(negedge clk);
        checkOutput("rstwait.no_wb2", {30'd0, wb_valid, dmem_req}, 32'd0);

        // Reset while requesting drops the request from the next cycle.
        ex_valid = 1'b1; opcode = OP_STORE; funct3 = 3'd2; alu_result = 32'h200;
        @(negedge clk);
        ex_valid = 1'b0; rst = 1'b1;
        checkOutput("rstreq.req", 32'(dmem_req), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstreq.dropped", {30'd0, stall, dmem_req}, 32'd0);
        @(negedge clk);
        checkOutput("rstreq.no_wb", 32'(wb_valid), 32'd0);

        for (int i = 0; i < 40; i++) begin
            rv = mk(OP_ALU, 0, 5'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                    $urandom, 1 + int'($urandom % 3), 1 + int'($urandom % 3),
                    0, 0, 0, 0, 0, 0, 0, 0);
            case ($urandom % 4)
                0: begin rv.opcode = alu_ops[$urandom % 3]; rv.funct3 = 3'($urandom); end
                1, 2: begin rv.opcode = OP_LOAD; rv.funct3 = ld_f3[$urandom % 5]; end
                default: begin rv.opcode = OP_STORE; rv.funct3 = 3'($urandom % 3); end
            endcase
            applyStimulus(model(rv), $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/core_mem_stage.md
# core_mem_stage

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of writeback. Registers the execute-stage result, runs loads and stores to the data memory over a request/grant/response handshake, and aligns store data and byte enables. Sign- or zero-extends load data and presents a single writeback beat per instruction. While a memory transaction is outstanding it stalls the upstream pipeline.

## Interface
- XLEN, 32, datapath width (only 32 supported)
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_ex_valid  in  1  execute stage presents an instruction this cycle
- i_opcode  in  7  RV32I opcode
- i_funct3  in  3  load/store width and sign
- i_rd  in  5  destination register
- i_reg_write  in  1  instruction writes rd
- i_alu_result  in  XLEN  ALU result; the byte address for loads and stores
- i_store_data  in  XLEN  forwarded rs2 value
- i_csr_data  in  XLEN  CSR read value
- o_stall  out  1  hold execute stage; it must not advance
- o_dmem_req  out  1  memory request valid
- o_dmem_we  out  1  1 = store
- o_dmem_addr  out  XLEN  word-aligned address, i.e. {addr[31:2], 2'b00}
- o_dmem_wdata  out  XLEN  lane-replicated store data
- o_dmem_be  out  4  byte enables; meaningful only for stores
- i_dmem_gnt  in  1  request accepted this cycle
- i_dmem_rvalid  in  1  load data valid
- i_dmem_rdata  in  XLEN  load data, full word
- o_wb_valid  out  1  one-cycle pulse per completed instruction
- o_wb_rd  out  5  destination register
- o_wb_reg_write  out  1  write enable for the register file
- o_wb_data  out  XLEN  writeback value
- o_misaligned  out  1  pulses with o_wb_valid for a misaligned access

## Operation
- FSM states:
  - IDLE: accepts when i_ex_valid = 1.
  - REQ: o_dmem_req held high.
  - WAIT: awaits load data.
- o_stall = (state != IDLE), combinational.
- Captured on accept: opcode, funct3, rd, reg_write, addr = i_alu_result, store data, CSR data.
- Non-memory instruction accepted in IDLE:
  - Next cycle: o_wb_valid = 1 and o_wb_rd = rd.
  - o_wb_reg_write = reg_write.
  - o_wb_data = i_csr_data if opcode is 1110011, else i_alu_result.
  - State stays IDLE.
- Load (0000011) or store (0100011), aligned:
  - IDLE → REQ.
  - In REQ, o_dmem_req = 1 with addr/we/wdata/be stable until i_dmem_gnt.
  - Store + gnt: IDLE; next cycle o_wb_valid = 1, o_wb_reg_write = 0.
  - Load + gnt: WAIT.
  - WAIT + i_dmem_rvalid: IDLE; next cycle o_wb_valid = 1 with extended data and o_wb_reg_write = reg_write.
- Misalignment:
  - Misaligned = (half access and addr[0]) or (word access and addr[1:0] != 0).
  - Byte accesses are never misaligned.
  - No memory request is issued; state stays IDLE.
  - Next cycle: o_wb_valid = 1, o_misaligned = 1, o_wb_reg_write = 0.
- Store lanes, with off = addr[1:0]:
  - SB (funct3 000): wdata = byte replicated ×4, be = 4'b0001 << off.
  - SH (001): wdata = half replicated ×2, be = 4'b0011 << off.
  - SW (010): wdata = data, be = 4'b1111.
- Load extraction: shifted = rdata >> (8·off).
  - LB (000) sign-extends shifted[7:0]; LBU (100) zero-extends it.
  - LH (001) sign-extends shifted[15:0]; LHU (101) zero-extends it.
  - LW (010) returns rdata.
- Loads with rd = 0 still complete normally; the register file ignores x0.
- o_dmem_req is never asserted outside REQ.
- i_dmem_rvalid outside WAIT is ignored.

## Timing
- Reset: state IDLE; o_dmem_req, o_dmem_we, o_dmem_be, o_wb_valid, o_wb_reg_write, o_misaligned = 0; o_dmem_addr, o_dmem_wdata, o_wb_data, o_wb_rd = 0.
- Reset asserted mid-transaction abandons it:
  - REQ/WAIT → IDLE on that edge.
  - o_dmem_req = 0 from the next cycle.
  - A late rvalid produces no writeback.
- Latency from accept edge to the o_wb_valid edge:
  - Non-memory or misaligned: 1 cycle.
  - Store: 1 + g cycles, where g = cycles in REQ (≥ 1).
  - Load: 1 + g + r cycles, where r = cycles in WAIT (≥ 1).
- i_dmem_rvalid is sampled only in WAIT, so a response in the same cycle as gnt is not supported. The memory must respond at least 1 cycle after gnt.
- Back-to-back non-memory instructions complete at 1 per cycle, with no stall.
- o_wb_valid is registered and high for exactly 1 cycle per instruction.

## Test plan
- Reset, then ADD with i_alu_result = 0x0000_0042, rd = 5 → next cycle o_wb_valid = 1, rd = 5, data = 0x42, o_stall = 0.
- SB with addr 0x1003 and data 0x0000_00AB, gnt after 2 REQ cycles:
  - Required: o_dmem_addr = 0x1000, be = 4'b1000, wdata = 0xABABABAB, o_stall high for 2 cycles.
  - Writeback pulse: o_wb_reg_write = 0.
- LH with addr 0x2002 and rdata 0x8001_7FFF → o_wb_data = 0xFFFF_8001. LHU on the same access → 0x0000_8001.
- LW with addr 0x3001 → no o_dmem_req; next cycle o_misaligned = 1 and o_wb_reg_write = 0.
- LB held in WAIT with rvalid delayed 3 cycles:
  - o_stall stays high throughout and the upstream instruction is not accepted.
  - Data: rdata 0x0000_0080 at off 0 → 0xFFFF_FF80.
- i_rst asserted while in WAIT, then rvalid arrives → no o_wb_valid, state IDLE, o_dmem_req = 0.
